conv3x3_rgb888_writer: RTL and testbench

Consumer end of the 3x3 RGB888 window stream: accepts one 3x3 window per valid pulse, throttles the window generator through a busy line, and convolves each colour channel with a 9-tap signed kernel. It then normalises and clamps the result and writes one RGB888 pixel per window into the output frame BRAM at sequential addresses. It sits between the window generator and the result frame buffer and completes a frame after WIDTH*HEIGHT writes.

---
 rtl/conv3x3_rgb888_writer.sv | 161 ++++++++++++++++
 tb/tb_conv3x3_rgb888_writer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_rgb888_writer.sv
// 3x3 RGB888 convolution sink: one window per valid pulse, one clamped
// pixel written to the output frame BRAM per window, sequential addresses.
module conv3x3_rgb888_writer #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 17,
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 272,
    parameter int DEPTH  = WIDTH * HEIGHT,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iEn,
    input  logic                  iValid,
    input  logic [DATA_W-1:0]     iIn0,
    input  logic [DATA_W-1:0]     iIn1,
    input  logic [DATA_W-1:0]     iIn2,
    input  logic [DATA_W-1:0]     iIn3,
    input  logic [DATA_W-1:0]     iIn4,
    input  logic [DATA_W-1:0]     iIn5,
    input  logic [DATA_W-1:0]     iIn6,
    input  logic [DATA_W-1:0]     iIn7,
    input  logic [DATA_W-1:0]     iIn8,
    input  logic [9*COEF_W-1:0]   iCoef,
    output logic                  oBusy,
    output logic                  oCs,
    output logic                  oWe,
    output logic [ADDR_W-1:0]     oAddr,
    output logic [DATA_W-1:0]     oPixel,
    output logic                  oDone
);

    localparam int ACC_W = 21;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        NORM,
        WRITE,
        DONE
    } state_t;

    state_t                    state;
    logic [DATA_W-1:0]         pix     [9];
    logic [COEF_W-1:0]         coef    [9];
    logic [DATA_W-1:0]         win_in  [9];
    logic [COEF_W-1:0]         coef_in [9];
    logic signed [ACC_W-1:0]   acc_r;
    logic signed [ACC_W-1:0]   acc_g;
    logic signed [ACC_W-1:0]   acc_b;
    logic [3:0]                tap;
    logic [DATA_W-1:0]         cur_pix;
    logic signed [COEF_W-1:0]  cur_coef;

    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0]  acc,
        input logic [7:0]               p,
        input logic signed [COEF_W-1:0] c
    );
        logic signed [8:0]        pu;
        logic signed [COEF_W+8:0] prod;
        pu   = $signed({1'b0, p});
        prod = pu * c;
        mac  = acc + ACC_W'(prod);
    endfunction

    function automatic logic [7:0] clamp(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [ACC_W-1:0] v;
        v = a >>> SHIFT;
        if (v < 0)
            clamp = 8'd0;
        else if (v > 255)
            clamp = 8'hFF;
        else
            clamp = v[7:0];
    endfunction

    assign win_in[0] = iIn0;
    assign win_in[1] = iIn1;
    assign win_in[2] = iIn2;
    assign win_in[3] = iIn3;
    assign win_in[4] = iIn4;
    assign win_in[5] = iIn5;
    assign win_in[6] = iIn6;
    assign win_in[7] = iIn7;
    assign win_in[8] = iIn8;

    for (genvar k = 0; k < 9; k++) begin : g_coef
        assign coef_in[k] = iCoef[COEF_W*k +: COEF_W];
    end

    assign cur_pix  = pix[tap];
    assign cur_coef = $signed(coef[tap]);

    // Decoded from registered state only; iValid never reaches oBusy.
    assign oBusy = (state == MAC) || (state == NORM) || (state == WRITE);
    assign oCs   = iEn && (state == WRITE);
    assign oWe   = iEn && (state == WRITE);
    assign oDone = (state == DONE);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state  <= IDLE;
            pix    <= '{default: '0};
            coef   <= '{default: '0};
            acc_r  <= '0;
            acc_g  <= '0;
            acc_b  <= '0;
            tap    <= '0;
            oAddr  <= '0;
            oPixel <= '0;
        end else if (iEn) begin
            unique case (state)
                IDLE: begin
                    if (iValid) begin
                        pix   <= win_in;
                        coef  <= coef_in;
                        acc_r <= '0;
                        acc_g <= '0;
                        acc_b <= '0;
                        tap   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc_r <= mac(acc_r, cur_pix[23:16], cur_coef);
                    acc_g <= mac(acc_g, cur_pix[15:8], cur_coef);
                    acc_b <= mac(acc_b, cur_pix[7:0], cur_coef);
                    tap   <= tap + 4'd1;
                    if (tap == 4'd8)
                        state <= NORM;
                end
                NORM: begin
                    oPixel <= {clamp(acc_r), clamp(acc_g), clamp(acc_b)};
                    state  <= WRITE;
                end
                WRITE: begin
                    if (oAddr == LAST) begin
                        oAddr <= '0;
                        state <= DONE;
                    end else begin
                        oAddr <= oAddr + 1'b1;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end else if (state == DONE) begin
            // Releasing enable after a frame re-arms for the next one.
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_conv3x3_rgb888_writer.sv
// Directed bench for conv3x3_rgb888_writer on a 4x3 frame with
// hand-computed pixels, throttle, freeze, frame-end and reset checks.
module tb_conv3x3_rgb888_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        valid = 1'b0;
    logic [23:0] win [9];
    logic [71:0] coef = '0;
    logic        busy;
    logic        cs;
    logic        we;
    logic [16:0] addr;
    logic [23:0] pixel;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv3x3_rgb888_writer #(
        .WIDTH (4),
        .HEIGHT(3),
        .DEPTH (12)
    ) dut (
        .iClk  (clk),
        .iRst  (rst_n),
        .iEn   (en),
        .iValid(valid),
        .iIn0  (win[0]),
        .iIn1  (win[1]),
        .iIn2  (win[2]),
        .iIn3  (win[3]),
        .iIn4  (win[4]),
        .iIn5  (win[5]),
        .iIn6  (win[6]),
        .iIn7  (win[7]),
        .iIn8  (win[8]),
        .iCoef (coef),
        .oBusy (busy),
        .oCs   (cs),
        .oWe   (we),
        .oAddr (addr),
        .oPixel(pixel),
        .oDone (done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [23:0] p);
        for (int k = 0; k < 9; k++) win[k] = p;
    endtask

    task automatic set_tap(input int k, input logic [7:0] v);
        coef[8*k +: 8] = v;
    endtask

    task automatic identity();
        coef = '0;
        set_tap(4, 8'd16);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " cs"}, 32'(cs), 32'd0);
        check({tag, " we"}, 32'(we), 32'd0);
        check({tag, " addr"}, 32'(addr), 32'd0);
        check({tag, " pixel"}, 32'(pixel), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
    endtask

    // Entered and left at posedge+2 with the DUT idle.
    task automatic run_window(input string tag, input logic [23:0] exp_pix,
                              input int exp_addr, input int stall_at,
                              input int stall_len);
        int          busy_n = 0;
        int          we_cnt = 0;
        int          we_n = 0;
        logic [23:0] wpix = '0;
        logic [16:0] waddr = '0;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            en = !(n >= stall_at && n < stall_at + stall_len);
            #1;
            if (busy) busy_n++;
            if (we) begin
                we_cnt++;
                we_n  = n;
                wpix  = pixel;
                waddr = addr;
            end
            if (!busy && en) break;
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        check({tag, " busy cycles"}, 32'(busy_n), 32'(11 + stall_len));
        check({tag, " write count"}, 32'(we_cnt), 32'd1);
        check({tag, " write cycle"}, 32'(we_n), 32'(11 + stall_len));
        check({tag, " addr"}, 32'(waddr), 32'(exp_addr));
        check({tag, " pixel"}, 32'(wpix), 32'(exp_pix));
    endtask

    initial begin
        int          wr_k;
        int          t_exp [3];
        logic [23:0] p_exp [3];
        int          cnt;
        fill(24'h0);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        en    = 1'b1;
        @(posedge clk);
        #2;

        fill(24'hABCDEF);
        win[4] = 24'h123456;
        identity();
        run_window("identity", 24'h123456, 0, 0, 0);

        fill(24'hFFFFFF);
        for (int k = 0; k < 9; k++) set_tap(k, 8'd16);
        run_window("clamp high", 24'hFFFFFF, 1, 0, 0);

        fill(24'h7F7F7F);
        win[4] = 24'h808080;
        coef = '0;
        set_tap(4, 8'hF0);
        run_window("clamp low", 24'h000000, 2, 0, 0);

        fill(24'hFFFFFF);
        win[4] = 24'h0A0A0A;
        win[1] = 24'h050505;
        win[3] = 24'h050505;
        win[5] = 24'h050505;
        win[7] = 24'h050505;
        coef = '0;
        set_tap(4, 8'h40);
        set_tap(1, 8'hF0);
        set_tap(3, 8'hF0);
        set_tap(5, 8'hF0);
        set_tap(7, 8'hF0);
        run_window("laplacian", 24'h141414, 3, 0, 0);

        // Valid held high; centre pixel changes every cycle.
        fill(24'h0);
        identity();
        t_exp = '{11, 23, 35};
        p_exp = '{24'h010101, 24'h0D0D0D, 24'h191919};
        wr_k  = 0;
        for (int t = 0; t < 36; t++) begin
            win[4] = {3{8'(t + 1)}};
            valid  = 1'b1;
            #1;
            if (we) begin
                if (wr_k < 3) begin
                    check("throttle write cycle", 32'(t), 32'(t_exp[wr_k]));
                    check("throttle addr", 32'(addr), 32'(4 + wr_k));
                    check("throttle pixel", 32'(pixel), 32'(p_exp[wr_k]));
                end
                wr_k++;
            end
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        check("throttle write count", 32'(wr_k), 32'd3);
        #1;

        fill(24'h101010);
        for (int k = 0; k < 9; k++) set_tap(k, 8'd1);
        run_window("freeze mac", 24'h090909, 7, 5, 3);

        fill(24'h0);
        win[4] = 24'h0055AA;
        identity();
        run_window("freeze write", 24'h0055AA, 8, 11, 2);

        win[4] = 24'h112233;
        run_window("frame 9", 24'h112233, 9, 0, 0);
        win[4] = 24'h445566;
        run_window("frame 10", 24'h445566, 10, 0, 0);
        win[4] = 24'h778899;
        run_window("frame 11", 24'h778899, 11, 0, 0);

        check("done after last", 32'(done), 32'd1);
        check("addr wraps", 32'(addr), 32'd0);
        valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("done ignores valid busy", 32'(busy), 32'd0);
        check("done held", 32'(done), 32'd1);
        valid = 1'b0;
        en = 1'b0;
        @(posedge clk);
        #1;
        check("done cleared", 32'(done), 32'd0);
        en = 1'b1;
        #1;

        fill(24'h0);
        win[4] = 24'h010203;
        run_window("new frame", 24'h010203, 0, 0, 0);

        win[4] = 24'h0F0F0F;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid mac busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (we || busy) cnt++;
        end
        check("no write after reset", 32'(cnt), 32'd0);

        win[4] = 24'hC0FFEE;
        run_window("after reset", 24'hC0FFEE, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
